// File: rtl/rsp_s1_prep_ahbic_in_stg_pkg.sv
// AHB input stage shared types.
// Transfer encodings and restart helper.
package rsp_s1_prep_ahbic_in_stg_pkg;

  localparam int AHB_ADDR_W = 32;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BU_SINGLE = 3'b000,
    BU_INCR   = 3'b001,
    BU_WRAP4  = 3'b010,
    BU_INCR4  = 3'b011,
    BU_WRAP8  = 3'b100,
    BU_INCR8  = 3'b101,
    BU_WRAP16 = 3'b110,
    BU_INCR16 = 3'b111
  } hburst_e;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef struct packed {
    logic [1:0] trans;
    logic       write;
    logic [2:0] size;
    logic [2:0] burst;
    logic [3:0] prot;
    logic       lock;
  } ctrl_t;

  // A held beat re-issued after losing grant
  // restarts as an undefined-length INCR.
  function automatic ctrl_t restart_ctrl(input ctrl_t c);
    ctrl_t r;
    r = c;
    if (c.trans == TR_SEQ)
      r.trans = TR_NONSEQ;
    if (c.burst != BU_SINGLE && c.burst != BU_INCR)
      r.burst = BU_INCR;
    return r;
  endfunction

endpackage

// File: rtl/rsp_s1_prep_ahbic_in_stg.sv
// AHB matrix input stage for one master port.
// Holds stalled address phases and re-issues them.
module rsp_s1_prep_ahbic_in_stg
  import rsp_s1_prep_ahbic_in_stg_pkg::*;
#(
  parameter int ADDR_WIDTH = AHB_ADDR_W
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  output logic                  HREADYOUTS,
  output logic                  HRESPS,
  input  logic                  active_dec,
  input  logic                  readyout_dec,
  input  logic                  resp_dec,
  output logic                  req_port,
  output logic                  sel_m,
  output logic [ADDR_WIDTH-1:0] addr_m,
  output logic [1:0]            trans_m,
  output logic                  write_m,
  output logic [2:0]            size_m,
  output logic [2:0]            burst_m,
  output logic [3:0]            prot_m,
  output logic                  mastlock_m
);

  logic                  pend_tran;
  logic                  data_phase;
  logic                  restart;
  logic                  err_last;
  logic [ADDR_WIDTH-1:0] hold_addr;
  ctrl_t                 hold_ctrl;
  ctrl_t                 ctrl_in;
  ctrl_t                 ctrl_o;

  logic trans_req;
  logic accepted;
  logic capture;
  logic cancel;
  logic pend_live;
  logic dp_set;
  logic dp_done;

  assign ctrl_in = '{
    trans: HTRANSS,
    write: HWRITES,
    size:  HSIZES,
    burst: HBURSTS,
    prot:  HPROTS,
    lock:  HMASTLOCKS
  };

  assign trans_req = HSELS & HTRANSS[1] & HREADYS;
  assign accepted  = active_dec & readyout_dec;
  assign capture   = trans_req & ~accepted;
  assign cancel    = pend_tran & err_last
                   & (HTRANSS == TR_IDLE);
  assign pend_live = pend_tran & ~cancel;
  assign dp_set    = accepted & (trans_req | pend_live);
  assign dp_done   = data_phase & readyout_dec;

  // Pending/data-phase/restart/error tracking
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_tran  <= 1'b0;
      data_phase <= 1'b0;
      restart    <= 1'b0;
      err_last   <= 1'b0;
    end else begin
      if (capture)
        pend_tran <= 1'b1;
      else if ((pend_tran & accepted) | cancel)
        pend_tran <= 1'b0;

      if (dp_set)
        data_phase <= 1'b1;
      else if (dp_done)
        data_phase <= 1'b0;

      if (capture)
        restart <= ~active_dec;
      else if ((pend_tran & accepted) | cancel)
        restart <= 1'b0;

      if (dp_done)
        err_last <= resp_dec;
      else if (trans_req)
        err_last <= 1'b0;
    end
  end

  // Holding register for a stalled address phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hold_addr <= '0;
      hold_ctrl <= '0;
    end else if (capture) begin
      hold_addr <= HADDRS;
      hold_ctrl <= ctrl_in;
    end
  end

  // Matrix-side mux: held transfer or master pass-through
  always_comb begin
    sel_m  = HSELS;
    addr_m = HADDRS;
    ctrl_o = ctrl_in;
    if (pend_live) begin
      sel_m  = 1'b1;
      addr_m = hold_addr;
      ctrl_o = restart ? restart_ctrl(hold_ctrl)
                       : hold_ctrl;
    end
  end

  assign trans_m    = ctrl_o.trans;
  assign write_m    = ctrl_o.write;
  assign size_m     = ctrl_o.size;
  assign burst_m    = ctrl_o.burst;
  assign prot_m     = ctrl_o.prot;
  assign mastlock_m = ctrl_o.lock;

  // Lock keeps the request up through IDLE
  assign req_port = pend_live
                  | (HSELS & (HTRANSS[1] | HMASTLOCKS));

  assign HREADYOUTS = pend_live  ? 1'b0 :
                      data_phase ? readyout_dec : 1'b1;
  assign HRESPS     = data_phase ? resp_dec : RESP_OKAY;

endmodule

// File: tb/tb_rsp_s1_prep_ahbic_in_stg.sv
// Randomized + directed bench for the AHB input stage.
// Reference model tracks the held transfer as a queue.
module tb_rsp_s1_prep_ahbic_in_stg;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HMASTLOCKS;
  logic        HREADYS;
  logic        HREADYOUTS;
  logic        HRESPS;
  logic        active_dec;
  logic        readyout_dec;
  logic        resp_dec;
  logic        req_port;
  logic        sel_m;
  logic [31:0] addr_m;
  logic [1:0]  trans_m;
  logic        write_m;
  logic [2:0]  size_m;
  logic [2:0]  burst_m;
  logic [3:0]  prot_m;
  logic        mastlock_m;

  always #5 HCLK = ~HCLK;

  rsp_s1_prep_ahbic_in_stg #(.ADDR_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HSELS(HSELS), .HADDRS(HADDRS),
    .HTRANSS(HTRANSS), .HWRITES(HWRITES),
    .HSIZES(HSIZES), .HBURSTS(HBURSTS),
    .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS),
    .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS),
    .HRESPS(HRESPS), .active_dec(active_dec),
    .readyout_dec(readyout_dec), .resp_dec(resp_dec),
    .req_port(req_port), .sel_m(sel_m),
    .addr_m(addr_m), .trans_m(trans_m),
    .write_m(write_m), .size_m(size_m),
    .burst_m(burst_m), .prot_m(prot_m),
    .mastlock_m(mastlock_m)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  tr;
    logic        wr;
    logic [2:0]  sz;
    logic [2:0]  bu;
    logic [3:0]  pr;
    logic        lk;
    logic        rs;
  } xfer_t;

  int    n_chk = 0;
  int    n_fail = 0;
  xfer_t held[$];
  bit    m_dp;
  bit    m_err;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    held.delete();
    m_dp  = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic mst(input logic s, input logic [1:0] t,
                     input logic w, input logic [31:0] a,
                     input logic [2:0] b, input logic r);
    HSELS      = s;
    HTRANSS    = t;
    HWRITES    = w;
    HADDRS     = a;
    HBURSTS    = b;
    HREADYS    = r;
    HSIZES     = 3'd2;
    HPROTS     = 4'h3;
    HMASTLOCKS = 1'b0;
  endtask

  task automatic grant(input logic a, input logic r,
                       input logic e);
    active_dec   = a;
    readyout_dec = r;
    resp_dec     = e;
  endtask

  // Check all outputs against the model, then clock it
  task automatic cyc(input string tag);
    bit trq, acc, cnl, live, dpd, act, rsp;
    xfer_t x, nx;
    logic [45:0] eb;
    logic er;
    #2;
    trq  = HSELS && HTRANSS >= 2 && HREADYS;
    acc  = active_dec && readyout_dec;
    act  = active_dec;
    rsp  = resp_dec;
    cnl  = held.size() > 0 && m_err && HTRANSS == 0;
    live = held.size() > 0 && !cnl;
    if (live) begin
      x = held[0];
      if (x.rs) begin
        if (x.tr == 3) x.tr = 2;
        if (x.bu >= 2) x.bu = 1;
      end
      eb = {x.addr, x.tr, x.wr, x.sz, x.bu, x.pr, x.lk};
    end else begin
      eb = {HADDRS, HTRANSS, HWRITES, HSIZES,
            HBURSTS, HPROTS, HMASTLOCKS};
    end
    er = live ? 1'b0 : (m_dp ? readyout_dec : 1'b1);
    chk({tag, "/rdy"}, 64'(HREADYOUTS), 64'(er));
    chk({tag, "/resp"}, 64'(HRESPS),
        64'(m_dp && resp_dec));
    chk({tag, "/req"}, 64'(req_port),
        64'(live || (HSELS && (HTRANSS >= 2 || HMASTLOCKS))));
    chk({tag, "/sel"}, 64'(sel_m), 64'(live ? 1'b1 : HSELS));
    chk({tag, "/bus"},
        64'({addr_m, trans_m, write_m, size_m,
             burst_m, prot_m, mastlock_m}), 64'(eb));
    dpd = m_dp && readyout_dec;
    nx = '{addr: HADDRS, tr: HTRANSS, wr: HWRITES,
           sz: HSIZES, bu: HBURSTS, pr: HPROTS,
           lk: HMASTLOCKS, rs: !act};
    @(posedge HCLK);
    if (dpd) m_err = rsp;
    else if (trq) m_err = 1'b0;
    if (acc && (trq || live)) m_dp = 1'b1;
    else if (dpd) m_dp = 1'b0;
    if (trq && !acc) begin
      held.delete();
      held.push_back(nx);
    end else if ((live && acc) || cnl) begin
      held.delete();
    end
    #1;
  endtask

  initial begin
    HRESETn = 1'b0;
    mst(0, 0, 0, 0, 0, 1);
    grant(0, 0, 0);
    model_reset();
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_rdy", 64'(HREADYOUTS), 64'(1));
    chk("rst_resp", 64'(HRESPS), 64'(0));
    chk("rst_req", 64'(req_port), 64'(0));
    chk("rst_sel", 64'(sel_m), 64'(0));
    chk("rst_trans", 64'(trans_m), 64'(0));
    HRESETn = 1'b1;

    // Granted pass-through
    grant(1, 1, 0);
    mst(1, 2, 0, 32'h1000, 0, 1);
    #1;
    chk("s1_addr", 64'(addr_m), 64'h1000);
    chk("s1_rdy", 64'(HREADYOUTS), 64'(1));
    cyc("s1a");
    mst(0, 0, 0, 0, 0, 1);
    #1;
    chk("s1_nopend", 64'(HREADYOUTS), 64'(1));
    cyc("s1b");

    // Not granted: hold, then issue on grant
    grant(0, 1, 0);
    mst(1, 2, 1, 32'h2000, 0, 1);
    #1;
    chk("s2_req", 64'(req_port), 64'(1));
    cyc("s2a");
    mst(1, 2, 1, 32'h2000, 0, 0);
    #1;
    chk("s2_stall", 64'(HREADYOUTS), 64'(0));
    cyc("s2b");
    cyc("s2c");
    cyc("s2d");
    grant(1, 1, 0);
    #1;
    chk("s2_addr", 64'(addr_m), 64'h2000);
    chk("s2_trans", 64'(trans_m), 64'(2));
    chk("s2_wr", 64'(write_m), 64'(1));
    cyc("s2e");
    mst(0, 0, 0, 0, 0, 0);
    grant(1, 0, 0);
    #1;
    chk("s2_dpwait", 64'(HREADYOUTS), 64'(0));
    cyc("s2f");
    grant(1, 1, 0);
    HREADYS = 1'b1;
    #1;
    chk("s2_dpdone", 64'(HREADYOUTS), 64'(1));
    cyc("s2g");

    // INCR4 broken by grant loss before beat 3
    grant(1, 1, 0);
    mst(1, 2, 0, 32'h3000, 3, 1);
    cyc("s3a");
    mst(1, 3, 0, 32'h3004, 3, 1);
    cyc("s3b");
    grant(0, 1, 0);
    mst(1, 3, 0, 32'h3008, 3, 1);
    cyc("s3c");
    mst(1, 3, 0, 32'h3008, 3, 0);
    cyc("s3d");
    cyc("s3e");
    grant(1, 1, 0);
    #1;
    chk("s3_trans", 64'(trans_m), 64'(2));
    chk("s3_burst", 64'(burst_m), 64'(1));
    chk("s3_addr", 64'(addr_m), 64'h3008);
    cyc("s3f");
    mst(0, 0, 0, 0, 0, 1);
    cyc("s3g");

    // ERROR response, then held transfer cancelled by IDLE
    grant(1, 1, 0);
    mst(1, 2, 1, 32'h4000, 0, 1);
    cyc("s4a");
    grant(1, 0, 1);
    mst(1, 2, 1, 32'h4010, 0, 0);
    #1;
    chk("s4_resp1", 64'(HRESPS), 64'(1));
    chk("s4_rdy1", 64'(HREADYOUTS), 64'(0));
    cyc("s4b");
    grant(0, 1, 1);
    mst(1, 2, 1, 32'h4010, 0, 1);
    #1;
    chk("s4_resp2", 64'(HRESPS), 64'(1));
    chk("s4_rdy2", 64'(HREADYOUTS), 64'(1));
    cyc("s4c");
    grant(1, 1, 0);
    mst(0, 0, 0, 0, 0, 1);
    #1;
    chk("s4_cx_trans", 64'(trans_m), 64'(0));
    chk("s4_cx_sel", 64'(sel_m), 64'(0));
    chk("s4_cx_req", 64'(req_port), 64'(0));
    cyc("s4d");
    #1;
    chk("s4_after_rdy", 64'(HREADYOUTS), 64'(1));
    chk("s4_after_trans", 64'(trans_m), 64'(0));
    cyc("s4e");

    // Reset while a transfer is held
    grant(0, 1, 0);
    mst(1, 2, 0, 32'h5000, 0, 1);
    cyc("s5a");
    mst(0, 0, 0, 0, 0, 0);
    #1;
    HRESETn = 1'b0;
    #1;
    chk("s5_rdy", 64'(HREADYOUTS), 64'(1));
    chk("s5_req", 64'(req_port), 64'(0));
    chk("s5_sel", 64'(sel_m), 64'(0));
    model_reset();
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    grant(0, 0, 0);
    mst(0, 0, 0, 0, 0, 1);
    #1;
    chk("s5_idle_rdy", 64'(HREADYOUTS), 64'(1));
    chk("s5_idle_resp", 64'(HRESPS), 64'(0));
    cyc("s5b");

    // Locked sequence keeps request through IDLE
    grant(1, 1, 0);
    mst(1, 2, 0, 32'h6000, 0, 1);
    HMASTLOCKS = 1'b1;
    cyc("s6a");
    mst(1, 0, 0, 32'h6004, 0, 1);
    HMASTLOCKS = 1'b1;
    #1;
    chk("s6_req", 64'(req_port), 64'(1));
    chk("s6_lock", 64'(mastlock_m), 64'(1));
    cyc("s6b");
    mst(1, 2, 0, 32'h6004, 0, 1);
    HMASTLOCKS = 1'b1;
    cyc("s6c");
    mst(0, 0, 0, 0, 0, 1);
    cyc("s6d");

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      HSELS        = ($urandom_range(0, 9) < 8);
      HTRANSS      = 2'($urandom_range(0, 3));
      HWRITES      = 1'($urandom);
      HADDRS       = {$urandom_range(0, 65535), 16'h0}
                   | 32'($urandom_range(0, 255) * 4);
      HSIZES       = 3'($urandom_range(0, 2));
      HBURSTS      = 3'($urandom_range(0, 7));
      HPROTS       = 4'($urandom);
      HMASTLOCKS   = ($urandom_range(0, 9) == 0);
      HREADYS      = ($urandom_range(0, 9) < 7);
      active_dec   = ($urandom_range(0, 9) < 6);
      readyout_dec = ($urandom_range(0, 9) < 7);
      resp_dec     = ($urandom_range(0, 9) < 2);
      cyc("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
